// File: rtl/azadi_spi_target.sv
// rtl/azadi_spi_target.sv - SPI mode-0 target with oversampled pins and tx holding register.
// Optional rx FIFO selected by AZADI_SPI_TGT_RXFIFO_EN (default: single-word rx register).
module azadi_spi_target #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              ss_ni,
    input  logic              sclk_i,
    input  logic              sd_i,
    output logic              sd_o,
    output logic              sd_oe,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    output logic              busy_o,
    output logic              underrun_o,
    output logic              ovf_o
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, sd_sync;
    logic                   ss_hist, sclk_hist;
    logic                   ss_s, sclk_s, sd_s;
    logic                   ss_fall, ss_rise, ss_edge, sclk_rise, sclk_fall;
    logic                   in_shift, sclk_rise_eff, sclk_fall_eff;
    logic                   load, word_done, load_pend;

    logic [DATA_W-1:0]      hold_q, shift_tx, rx_word;
    logic                   hold_full, underrun_q;
    logic [DATA_W-2:0]      rx_shift;
    logic [CNT_W-1:0]       bit_cnt;

    // Synchronizers idle at the deselected, clock-low pin levels.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ss_sync   <= '1;
            sclk_sync <= '0;
            sd_sync   <= '0;
            ss_hist   <= 1'b1;
            sclk_hist <= 1'b0;
        end else begin
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_ni};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
            sd_sync   <= {sd_sync[SYNC_STAGES-2:0], sd_i};
            ss_hist   <= ss_s;
            sclk_hist <= sclk_s;
        end
    end

    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign sd_s      = sd_sync[SYNC_STAGES-1];
    assign ss_fall   = ss_hist & ~ss_s;
    assign ss_rise   = ~ss_hist & ss_s;
    assign ss_edge   = ss_fall | ss_rise;
    assign sclk_rise = ~sclk_hist & sclk_s;
    assign sclk_fall = sclk_hist & ~sclk_s;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ss_fall) state_d = SHIFT;
            SHIFT:   if (ss_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A select edge masks any sclk edge seen in the same cycle.
    assign in_shift      = (state_q == SHIFT);
    assign sclk_rise_eff = in_shift & sclk_rise & ~ss_edge;
    assign sclk_fall_eff = in_shift & sclk_fall & ~ss_edge;
    assign load          = (~in_shift & ss_fall) | (sclk_fall_eff & load_pend);
    assign word_done     = sclk_rise_eff & (bit_cnt == LAST_BIT);
    assign rx_word       = {rx_shift, sd_s};

    assign sd_o       = in_shift ? shift_tx[DATA_W-1] : 1'b1;
    assign sd_oe      = in_shift;
    assign busy_o     = in_shift;
    assign tx_ready_o = ~hold_full;
    assign underrun_o = underrun_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            hold_q     <= '0;
            hold_full  <= 1'b0;
            shift_tx   <= '1;
            rx_shift   <= '0;
            bit_cnt    <= '0;
            load_pend  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            if (load) begin
                // An empty holding register lets a same-cycle tx word pass straight through.
                underrun_q <= ~hold_full & ~tx_valid_i;
                if (hold_full) begin
                    shift_tx  <= hold_q;
                    hold_full <= 1'b0;
                end else if (tx_valid_i) begin
                    shift_tx <= tx_data_i;
                end else begin
                    shift_tx <= '1;
                end
            end else begin
                underrun_q <= 1'b0;
                if (sclk_fall_eff)
                    shift_tx <= {shift_tx[DATA_W-2:0], 1'b1};
                if (tx_valid_i && !hold_full) begin
                    hold_q    <= tx_data_i;
                    hold_full <= 1'b1;
                end
            end

            if (load || (in_shift && ss_rise))
                load_pend <= 1'b0;
            else if (word_done)
                load_pend <= 1'b1;

            if (ss_edge)
                bit_cnt <= '0;
            else if (sclk_rise_eff)
                bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + CNT_W'(1);

            if (sclk_rise_eff)
                rx_shift <= rx_word[DATA_W-2:0];
        end
    end

`ifdef AZADI_SPI_TGT_RXFIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr, rd_ptr;
    logic              fifo_empty, fifo_full, pop, push_ok;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop        = ~fifo_empty & rx_ready_i;
    assign push_ok    = word_done & (~fifo_full | pop);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_o  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            if (push_ok) begin
                fifo_mem[wr_ptr[PTR_W-1:0]] <= rx_word;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (word_done && fifo_full && !pop)
                ovf_o <= 1'b1;
        end
    end

    assign rx_valid_o = ~fifo_empty;
    assign rx_data_o  = fifo_mem[rd_ptr[PTR_W-1:0]];
`else
    logic                       unused_rx_ready;
    logic [$clog2(FIFO_DEPTH):0] unused_fifo_depth;

    assign unused_rx_ready   = rx_ready_i;
    assign unused_fifo_depth = '0;
    assign ovf_o             = 1'b0;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rx_data_o  <= '0;
            rx_valid_o <= 1'b0;
        end else begin
            rx_valid_o <= word_done;
            if (word_done)
                rx_data_o <= rx_word;
        end
    end
`endif

endmodule

// File: tb/tb_azadi_spi_target.sv
// tb/tb_azadi_spi_target.sv - directed SPI master bench with rx scoreboard for azadi_spi_target.
module tb_azadi_spi_target;

    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       ss_n, sclk, mosi;
    logic       miso, miso_oe;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready;
    logic       busy, underrun, ovf;

    int         vectors = 0;
    int         errors  = 0;
    int         und_cnt = 0;
    int         und0;
    logic [7:0] sbq[$];
    logic [7:0] got, got2;

    azadi_spi_target #(.DATA_W(8), .SYNC_STAGES(2), .FIFO_DEPTH(4)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .ss_ni      (ss_n),
        .sclk_i     (sclk),
        .sd_i       (mosi),
        .sd_o       (miso),
        .sd_oe      (miso_oe),
        .tx_data_i  (tx_data),
        .tx_valid_i (tx_valid),
        .tx_ready_o (tx_ready),
        .rx_data_o  (rx_data),
        .rx_valid_o (rx_valid),
        .rx_ready_i (rx_ready),
        .busy_o     (busy),
        .underrun_o (underrun),
        .ovf_o      (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard consumer: each delivered rx word must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && rx_valid && rx_ready) begin
            if (sbq.size() == 0) begin
                chk("rx_unexpected", {24'h0, rx_data}, 32'hdead);
            end else begin
                chk("rx_data", {24'h0, rx_data}, {24'h0, sbq.pop_front()});
            end
        end
        if (underrun) und_cnt++;
    end

    task automatic tx_write(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        clks(1);
        tx_valid = 1'b0;
    endtask

    task automatic ss_low();
        ss_n = 1'b0;
        clks(HALF);
    endtask

    // Mode 0: drive MOSI while sclk low, sample MISO at the rise.
    // When 'last', select is released while sclk is still high, so no trailing load point.
    task automatic xfer(input logic [7:0] d, input int nbits, input bit last,
                        output logic [7:0] m);
        m = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = d[7-i];
            clks(HALF);
            sclk = 1'b1;
            m[7-i] = miso;
            clks(HALF);
            if (last && i == nbits - 1) begin
                ss_n = 1'b1;
                clks(HALF);
                sclk = 1'b0;
                clks(HALF);
            end else begin
                sclk = 1'b0;
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_sd_o"},     {31'h0, miso},     32'h1);
        chk({tag, "_sd_oe"},    {31'h0, miso_oe},  32'h0);
        chk({tag, "_tx_ready"}, {31'h0, tx_ready}, 32'h1);
        chk({tag, "_rx_data"},  {24'h0, rx_data},  32'h0);
        chk({tag, "_rx_valid"}, {31'h0, rx_valid}, 32'h0);
        chk({tag, "_busy"},     {31'h0, busy},     32'h0);
        chk({tag, "_underrun"}, {31'h0, underrun}, 32'h0);
        chk({tag, "_ovf"},      {31'h0, ovf},      32'h0);
    endtask

    initial begin
        rst = 1'b1; ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b1;
        clks(4);
        chk_reset_outputs("reset");
        rst = 1'b0;
        clks(4);

        // 1: preloaded 0xA5 returned while 0x3C is received
        und0 = und_cnt;
        tx_write(8'hA5);
        chk("t1_ready_after_write", {31'h0, tx_ready}, 32'h0);
        sbq.push_back(8'h3C);
        ss_low();
        chk("t1_busy", {31'h0, busy}, 32'h1);
        chk("t1_sd_oe", {31'h0, miso_oe}, 32'h1);
        chk("t1_ready_after_load", {31'h0, tx_ready}, 32'h1);
        xfer(8'h3C, 8, 1'b1, got);
        chk("t1_miso", {24'h0, got}, 32'hA5);
        chk("t1_underruns", und_cnt - und0, 0);
        chk("t1_idle_sd_o", {31'h0, miso}, 32'h1);

        // 2: empty tx -> all-ones and one underrun at select
        und0 = und_cnt;
        sbq.push_back(8'h5A);
        ss_low();
        xfer(8'h5A, 8, 1'b1, got);
        chk("t2_miso", {24'h0, got}, 32'hFF);
        chk("t2_underruns", und_cnt - und0, 1);

        // 3: two-word frame, second tx word written after the first load
        und0 = und_cnt;
        tx_write(8'h12);
        sbq.push_back(8'hC3);
        sbq.push_back(8'h96);
        ss_low();
        tx_write(8'h34);
        xfer(8'hC3, 8, 1'b0, got);
        xfer(8'h96, 8, 1'b1, got2);
        chk("t3_miso_w0", {24'h0, got}, 32'h12);
        chk("t3_miso_w1", {24'h0, got2}, 32'h34);
        chk("t3_underruns", und_cnt - und0, 0);

        // 4: frame aborted after 5 bits, then a clean 0x81 frame
        ss_low();
        xfer(8'hE7, 5, 1'b1, got);
        clks(4);
        chk("t4_sd_oe", {31'h0, miso_oe}, 32'h0);
        chk("t4_busy", {31'h0, busy}, 32'h0);
        chk("t4_sd_o", {31'h0, miso}, 32'h1);
        chk("t4_no_rx", sbq.size(), 0);
        sbq.push_back(8'h81);
        ss_low();
        xfer(8'h81, 8, 1'b1, got);
        chk("t4_miso", {24'h0, got}, 32'hFF);

`ifdef AZADI_SPI_TGT_RXFIFO_EN
        // 5: five words into a 4-deep FIFO with the consumer stalled
        rx_ready = 1'b0;
        sbq.push_back(8'h11);
        sbq.push_back(8'h22);
        sbq.push_back(8'h33);
        sbq.push_back(8'h44);
        ss_low();
        xfer(8'h11, 8, 1'b0, got);
        xfer(8'h22, 8, 1'b0, got);
        xfer(8'h33, 8, 1'b0, got);
        xfer(8'h44, 8, 1'b0, got);
        xfer(8'h55, 8, 1'b1, got);
        clks(4);
        chk("t5_ovf", {31'h0, ovf}, 32'h1);
        chk("t5_rx_valid", {31'h0, rx_valid}, 32'h1);
        rx_ready = 1'b1;
        clks(10);
        chk("t5_drained", sbq.size(), 0);
        chk("t5_empty", {31'h0, rx_valid}, 32'h0);
        chk("t5_ovf_sticky", {31'h0, ovf}, 32'h1);
`else
        chk("ovf_tied", {31'h0, ovf}, 32'h0);
`endif

        // 6: reset in the middle of a word, then a full frame
        tx_write(8'h5C);
        ss_low();
        xfer(8'hF0, 3, 1'b0, got);
        rst = 1'b1;
        clks(1);
        chk_reset_outputs("t6_reset");
        ss_n = 1'b1;
        sclk = 1'b0;
        clks(3);
        rst = 1'b0;
        clks(4);
        und0 = und_cnt;
        tx_write(8'h6E);
        sbq.push_back(8'hB7);
        ss_low();
        xfer(8'hB7, 8, 1'b1, got);
        chk("t6_miso", {24'h0, got}, 32'h6E);
        chk("t6_underruns", und_cnt - und0, 0);

        clks(10);
        chk("final_scoreboard_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
